// File: rtl/coax_rx_buffer.sv
// coax_rx_buffer: drains the coax receiver's single-word holding register
// into a first-word-fall-through FIFO. It runs the receiver's read
// handshake, keeps sticky frame/error status, and provides a host clear
// that flushes the buffer and pulses the receiver reset.
module coax_rx_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_active,
  input  logic          rx_error,
  input  logic [9:0]    rx_data,
  input  logic          rx_data_available,
  output logic          rx_read,
  output logic          rx_reset,
  output logic [9:0]    fifo_data,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [AW:0]   fifo_count,
  input  logic          pop,
  input  logic          clear,
  output logic          frame_complete,
  output logic          error,
  output logic [9:0]    error_code
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [9:0] CODE_OVERFLOW = 10'b0000010000;

  state_t        state_r, state_s;
  logic          rx_read_r, rx_read_s;
  logic          capture_s;
  logic          rx_reset_r;
  logic [9:0]    data_r;
  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r, count_s;
  logic          empty_r, full_r;
  logic          push_s, pop_s, wr_en_s, overflow_s;
  logic          rx_error_q_r, rx_active_q_r;
  logic          rx_error_rise_s, rx_active_rise_s, rx_active_fall_s;
  logic          frame_r, error_r;
  logic [9:0]    code_r;

  // Handshake next-state and read strobe; clear forces IDLE and drops any capture.
  always_comb begin
    state_s   = state_r;
    rx_read_s = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_data_available && !rx_error) begin
          capture_s = 1'b1;
          state_s   = ST_ACK;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_ACK: begin
        rx_read_s = 1'b1;
        state_s   = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!rx_data_available) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (clear) begin
      state_s   = ST_IDLE;
      rx_read_s = 1'b0;
      capture_s = 1'b0;
    end else begin
      state_s   = state_s;
    end
  end

  // Handshake state, read strobe, receiver reset pulse and captured word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      rx_read_r  <= 1'b0;
      rx_reset_r <= 1'b1;
      data_r     <= 10'd0;
    end else begin
      state_r    <= state_s;
      rx_read_r  <= rx_read_s;
      rx_reset_r <= clear;
      if (capture_s) begin
        data_r <= rx_data;
      end
    end
  end

  // The captured word is pushed during the ACK cycle; a full FIFO drops it
  // unless a pop frees a slot in the same cycle.
  always_comb begin
    push_s     = (state_r == ST_ACK) && !clear;
    pop_s      = pop && !empty_r && !clear;
    wr_en_s    = push_s && (!full_r || pop_s);
    overflow_s = push_s && full_r && !pop_s;
    if (wr_en_s && !pop_s) begin
      count_s = count_r + (AW+1)'(1);
    end else if (!wr_en_s && pop_s) begin
      count_s = count_r - (AW+1)'(1);
    end else begin
      count_s = count_r;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= data_r;
    end
  end

  // FIFO pointers and registered occupancy flags.
  always_ff @(posedge clk) begin
    if (!reset || (reset && clear)) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_s;
      empty_r <= (count_s == {(AW+1){1'b0}});
      full_r  <= (count_s == (AW+1)'(DEPTH));
    end
  end

  // Edge detection on the receiver's level flags.
  always_comb begin
    rx_error_rise_s  = rx_error && !rx_error_q_r;
    rx_active_rise_s = rx_active && !rx_active_q_r;
    rx_active_fall_s = !rx_active && rx_active_q_r;
  end

  // Sticky frame/error status; the first error code is kept until clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_error_q_r  <= 1'b0;
      rx_active_q_r <= 1'b0;
      frame_r       <= 1'b0;
      error_r       <= 1'b0;
      code_r        <= 10'd0;
    end else begin
      rx_error_q_r  <= rx_error;
      rx_active_q_r <= rx_active;
      if (clear) begin
        frame_r <= 1'b0;
      end else if (rx_active_fall_s && !rx_error) begin
        frame_r <= 1'b1;
      end else if (rx_active_rise_s) begin
        frame_r <= 1'b0;
      end
      if (clear) begin
        error_r <= 1'b0;
        code_r  <= 10'd0;
      end else if (!error_r && rx_error_rise_s) begin
        error_r <= 1'b1;
        code_r  <= rx_data;
      end else if (!error_r && overflow_s) begin
        error_r <= 1'b1;
        code_r  <= CODE_OVERFLOW;
      end
    end
  end

  assign rx_read        = rx_read_r;
  assign rx_reset       = rx_reset_r;
  assign fifo_data      = mem_r[rd_ptr_r];
  assign fifo_empty     = empty_r;
  assign fifo_full      = full_r;
  assign fifo_count     = count_r;
  assign frame_complete = frame_r;
  assign error          = error_r;
  assign error_code     = code_r;

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Self-checking bench for coax_rx_buffer: a status/edge vector table,
// hand-written handshake and FIFO corner sequences, and a randomized
// transaction phase compared with a queue-based reference model.
module tb_coax_rx_buffer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_active, rx_error, rx_data_available, pop, clear;
  logic [9:0]    rx_data;
  logic          rx_read, rx_reset, fifo_empty, fifo_full;
  logic          frame_complete, error;
  logic [9:0]    fifo_data, error_code;
  logic [AW:0]   fifo_count;

  int checks = 0;
  int errors = 0;

  coax_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_active(rx_active), .rx_error(rx_error),
    .rx_data(rx_data), .rx_data_available(rx_data_available),
    .rx_read(rx_read), .rx_reset(rx_reset), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .pop(pop), .clear(clear), .frame_complete(frame_complete),
    .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic active;
    logic err;
    logic clr;
    logic exp_frame;
    logic exp_error;
    logic exp_rx_reset;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and behaves like the receiver: holds available until
  // rx_read falls, then drops it. Returns the number of rx_read-high cycles.
  task automatic send_word(input logic [9:0] w, output int hi);
    logic seen, ok;
    hi = 0; seen = 1'b0; ok = 1'b0;
    rx_data = w;
    rx_data_available = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rx_read) begin
        hi++;
        seen = 1'b1;
      end else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    rx_data_available = 1'b0;
    tick();
    chk("handshake_done", ok, 1'b1);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Reference model state for the randomized phase.
  logic [9:0] mq[$];
  logic       m_err;
  logic [9:0] m_code;

  initial begin
    int hi;
    int seen_read;
    logic [9:0] w;
    logic [9:0] exp_w;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b0; rx_active = 1'b0; rx_error = 1'b0; rx_data = 10'd0;
    rx_data_available = 1'b0; pop = 1'b0; clear = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_rx_read", rx_read, 1'b0);
    chk("rst_rx_reset", rx_reset, 1'b1);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_count", fifo_count, 5'd0);
    chk("rst_frame", frame_complete, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_code", error_code, 10'd0);
    reset = 1'b1;
    tick();
    chk("rx_reset_after_rst", rx_reset, 1'b0);

    // Frame/error/clear vector table
    rx_data = 10'h002;
    for (int i = 0; i < 11; i++) begin
      rx_active = vecs[i].active;
      rx_error  = vecs[i].err;
      clear     = vecs[i].clr;
      tick();
      clear = 1'b0;
      chk($sformatf("vec%0d_frame", i), frame_complete, vecs[i].exp_frame);
      chk($sformatf("vec%0d_error", i), error, vecs[i].exp_error);
      chk($sformatf("vec%0d_rx_reset", i), rx_reset, vecs[i].exp_rx_reset);
    end
    rx_error = 1'b0;

    // Single word with latency checks
    rx_data = 10'h2A5;
    rx_data_available = 1'b1;
    tick();
    chk("sw_empty_c1", fifo_empty, 1'b1);
    chk("sw_read_c1", rx_read, 1'b0);
    tick();
    chk("sw_empty_c2", fifo_empty, 1'b0);
    chk("sw_count_c2", fifo_count, 5'd1);
    chk("sw_data_c2", fifo_data, 10'h2A5);
    chk("sw_read_c2", rx_read, 1'b1);
    tick();
    chk("sw_read_c3", rx_read, 1'b0);
    rx_data_available = 1'b0;
    tick();
    chk("sw_read_c4", rx_read, 1'b0);
    do_pop();
    chk("sw_pop_empty", fifo_empty, 1'b1);
    chk("sw_pop_count", fifo_count, 5'd0);

    // Burst of DEPTH+1 words without pops
    for (int i = 0; i <= DEPTH; i++) begin
      send_word(10'(i), hi);
      if (i == DEPTH - 1) begin
        chk("burst_full", fifo_full, 1'b1);
        chk("burst_count", fifo_count, 5'd16);
        chk("burst_no_err", error, 1'b0);
      end
    end
    chk("ovf_handshake", hi, 1);
    chk("ovf_error", error, 1'b1);
    chk("ovf_code", error_code, 10'h010);
    chk("ovf_count", fifo_count, 5'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("burst_pop%0d", i), fifo_data, 10'(i));
      do_pop();
    end
    chk("burst_drained", fifo_empty, 1'b1);

    // Clear pulses rx_reset and clears sticky error
    do_clear();
    chk("clr_rx_reset", rx_reset, 1'b1);
    chk("clr_error", error, 1'b0);
    chk("clr_code", error_code, 10'd0);
    tick();
    chk("clr_rx_reset_end", rx_reset, 1'b0);

    // Simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) send_word(10'h100 + 10'(i), hi);
    rx_data = 10'h3FF;
    rx_data_available = 1'b1;
    tick();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pp_count", fifo_count, 5'd16);
    chk("pp_full", fifo_full, 1'b1);
    chk("pp_error", error, 1'b0);
    chk("pp_head", fifo_data, 10'h101);
    tick();
    rx_data_available = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      exp_w = (i < DEPTH - 1) ? 10'h101 + 10'(i) : 10'h3FF;
      chk($sformatf("pp_pop%0d", i), fifo_data, exp_w);
      do_pop();
    end
    chk("pp_drained", fifo_empty, 1'b1);

    // Receiver error blocks capture; clear recovers
    rx_data = 10'h002;
    rx_error = 1'b1;
    tick();
    chk("rxe_error", error, 1'b1);
    chk("rxe_code", error_code, 10'h002);
    rx_data = 10'h155;
    rx_data_available = 1'b1;
    seen_read = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rx_read) seen_read++;
    end
    chk("rxe_no_read", seen_read, 0);
    chk("rxe_empty", fifo_empty, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rx_error = 1'b0;
    rx_data_available = 1'b0;
    chk("rxe_clr_rx_reset", rx_reset, 1'b1);
    chk("rxe_clr_error", error, 1'b0);
    chk("rxe_clr_empty", fifo_empty, 1'b1);
    tick();
    chk("rxe_clr_rx_reset_end", rx_reset, 1'b0);

    // Reset in the middle of a handshake
    send_word(10'h0AA, hi);
    chk("mid_pre_count", fifo_count, 5'd1);
    rx_data = 10'h1C3;
    rx_data_available = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rx_read", rx_read, 1'b0);
    chk("mid_rx_reset", rx_reset, 1'b1);
    chk("mid_empty", fifo_empty, 1'b1);
    reset = 1'b1;
    rx_data_available = 1'b0;
    tick();
    chk("mid_rx_reset_end", rx_reset, 1'b0);
    send_word(10'h1C3, hi);
    chk("mid_resume_hs", hi, 1);
    chk("mid_resume_count", fifo_count, 5'd1);
    chk("mid_resume_data", fifo_data, 10'h1C3);
    do_pop();

    // Randomized transactions against the queue model
    do_clear();
    tick();
    mq.delete();
    m_err = 1'b0;
    m_code = 10'd0;
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 52) begin
        w = 10'($urandom_range(0, 1023));
        send_word(w, hi);
        if (mq.size() < DEPTH) begin
          mq.push_back(w);
        end else if (!m_err) begin
          m_err = 1'b1;
          m_code = 10'h010;
        end
      end else if (r < 97) begin
        if (mq.size() > 0) chk("rnd_pop_data", fifo_data, mq[0]);
        do_pop();
        if (mq.size() > 0) void'(mq.pop_front());
      end else begin
        do_clear();
        tick();
        mq.delete();
        m_err = 1'b0;
        m_code = 10'd0;
      end
      chk("rnd_count", fifo_count, mq.size());
      chk("rnd_empty", fifo_empty, (mq.size() == 0));
      chk("rnd_full", fifo_full, (mq.size() == DEPTH));
      chk("rnd_error", error, m_err);
      chk("rnd_code", error_code, m_code);
      if (mq.size() > 0) chk("rnd_head", fifo_data, mq[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
